// File: rtl/mesh_edge_port.sv
// mesh_edge_port: virtual east-edge neighbour for one mesh row.
// Drains outbound PE packets into a host FIFO and injects host packets.
// Ports: clk, rst_n; i_PE/o_PE PE link; i_align link enable;
//   tx_* host->mesh stream; rx_* mesh->host stream; rx_count occupancy;
//   err_key sticky illegal-key drop flag; inj_count/ej_count statistics.
// Optional macro: EDGE_PORT_STATS_EN builds the saturating counters.
module mesh_edge_port #(
   parameter int N          = 1024,
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 10,
   parameter int EDGE_I     = 31,
   parameter int FIFO_DEPTH = 8,
   localparam int WIDTH     = ADDR_WIDTH + DATA_WIDTH,
   localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_PE,
   output logic [WIDTH-1:0] o_PE,
   input  logic             i_align,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [WIDTH-1:0] tx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic [CW-1:0]    rx_count,
   output logic             err_key,
   output logic [15:0]      inj_count,
   output logic [15:0]      ej_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] EMPTY = ADDR_WIDTH'(N);
   localparam logic [ADDR_WIDTH-1:0] BLOCK = '1;
   localparam logic [ADDR_WIDTH-1:0] EDGE  = ADDR_WIDTH'(EDGE_I);
   localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] MARGIN = CW'(FIFO_DEPTH - 2);

   logic [WIDTH-1:0]      link_reg;
   logic [WIDTH-1:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [ADDR_WIDTH-1:0] pk;
   logic [ADDR_WIDTH-1:0] lk;
   logic [ADDR_WIDTH-1:0] tk;
   logic                  consumed;
   logic                  capture;
   logic                  load;
   logic                  load_ok;
   logic                  pop;

   assign pk = i_PE[WIDTH-1:DATA_WIDTH];
   assign lk = link_reg[WIDTH-1:DATA_WIDTH];
   assign tk = tx_data[WIDTH-1:DATA_WIDTH];

   // PE accepts our inbound word when it has nothing inbound-bound itself.
   assign consumed = i_align && lk != EMPTY && lk <= EDGE &&
                     (pk == EMPTY || pk > EDGE);
   assign capture  = i_align && pk != EMPTY && pk > EDGE &&
                     (lk == EMPTY || lk <= EDGE) && rx_count < FULL;

   // Two free slots reserved so a capture always fits behind a loaded word.
   assign tx_ready = (lk == EMPTY) && rx_count <= MARGIN;
   assign load     = tx_valid && tx_ready;
   assign load_ok  = load && tk <= EDGE;

   assign rx_valid = rx_count != '0;
   assign rx_data  = mem[rd_ptr];
   assign pop      = rx_valid && rx_ready;

   // A full FIFO with nothing to offer shows BLOCK so the PE holds its packet.
   assign o_PE = (lk == EMPTY && rx_count == FULL) ?
                 {BLOCK, {DATA_WIDTH{1'b0}}} : link_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_reg <= {EMPTY, {DATA_WIDTH{1'b0}}};
         err_key  <= 1'b0;
      end else begin
         if (load_ok)
            link_reg <= tx_data;
         else if (consumed || capture)
            link_reg <= {EMPTY, {DATA_WIDTH{1'b0}}};
         if (load && !load_ok)
            err_key <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rx_count <= '0;
      end else begin
         if (capture)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (capture && !pop)
            rx_count <= rx_count + 1'b1;
         else if (pop && !capture)
            rx_count <= rx_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (capture)
         mem[wr_ptr] <= i_PE;
   end

`ifdef EDGE_PORT_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inj_count <= '0;
         ej_count  <= '0;
      end else begin
         if (load_ok && inj_count != 16'hFFFF)
            inj_count <= inj_count + 1'b1;
         if (capture && ej_count != 16'hFFFF)
            ej_count <= ej_count + 1'b1;
      end
   end
`else
   assign inj_count = '0;
   assign ej_count  = '0;
`endif

endmodule

// File: doc/mesh_edge_port.md
# mesh_edge_port

Virtual east-edge neighbour for one mesh row. It drains key/data packets that the row's last PE pushes outward during column alignment into a host-side FIFO, and it injects host packets into that PE through the same link. It is the off-mesh counterpart of the PE's `i_PE_r` link and speaks the PE swap protocol: a packet word is `{key, data}`, and `key == N` means an empty slot.

## Interface
Parameters:
- `N`, 1024: PE count; the key value `N` is the empty-slot marker (MAX_INT).
- `ADDR_WIDTH`, 11: key width; requires `N < 2^ADDR_WIDTH - 1`.
- `DATA_WIDTH`, 10: payload width; `WIDTH = ADDR_WIDTH + DATA_WIDTH`.
- `EDGE_I`, 31: index of the adjacent (last-in-row) PE.
- `FIFO_DEPTH`, 8: receive FIFO depth; a power of 2 and ≥ 2.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `i_PE`  in  WIDTH: the adjacent PE's `o_PE`.
- `o_PE`  out  WIDTH: drives the adjacent PE's `i_PE_r`.
- `i_align`  in  1: the row is in COL_ALIGN; the link is active.
- `tx_valid`, `tx_ready`, `tx_data[WIDTH-1:0]`: host→mesh inject stream.
- `rx_valid`, `rx_ready`, `rx_data[WIDTH-1:0]`: mesh→host eject stream.
- `rx_count`  out  clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `err_key`  out  1: sticky; set when a tx packet is dropped for an illegal key.
- `inj_count`, `ej_count`  out  16 each: statistics (see Configuration).

## Operation
- Internal state: `link_reg` (WIDTH), receive FIFO, `err_key`. Notation: `pk = i_PE` key, `lk = link_reg` key, `EMPTY = N`, `BLOCK = 2^ADDR_WIDTH - 1`.
- `consumed` = `i_align && lk != EMPTY && lk <= EDGE_I && (pk == EMPTY || pk > EDGE_I)`. The PE takes the inbound word.
- `capture` = `i_align && pk != EMPTY && pk > EDGE_I && (lk == EMPTY || lk <= EDGE_I) && rx_count < FIFO_DEPTH`. The PE's outbound word is pushed into the FIFO.
- If `consumed || capture`, then `link_reg <= {EMPTY, 0}`. Exchange is symmetric: the PE takes whatever `o_PE` showed.
- `o_PE` = `{BLOCK, 0}` when `lk == EMPTY && rx_count == FIFO_DEPTH`; otherwise `link_reg`. BLOCK is neither EMPTY nor ≤ EDGE_I, so the PE holds its packet.
- Load (tx handshake):
  - `tx_ready = (lk == EMPTY) && rx_count <= FIFO_DEPTH-2`.
  - The 2-entry margin guarantees that a captured packet always has a slot while an inbound word sits in the link.
  - On `tx_valid && tx_ready`: if the tx key ≤ EDGE_I, `link_reg <= tx_data`. Otherwise (outbound or EMPTY key) the packet is dropped and `err_key <= 1`.
  - A load may coincide with a `capture` on an empty link; the load wins the `link_reg` write.
- FIFO:
  - `rx_valid = rx_count != 0`; `rx_data` = head.
  - Pop on `rx_valid && rx_ready`.
  - Push and pop in the same cycle leave `rx_count` unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
- With `i_align = 0`, no link exchange occurs. Loads and pops continue.

## Timing
- Reset (async assert, sync release): `link_reg = {N,0}`, `o_PE = {N,0}`, FIFO empty, `rx_valid = 0`, `rx_count = 0`, `err_key = 0`, stats = 0. `tx_ready = 1` once `rx_n` is high.
- Inject latency: a tx handshake in cycle t puts the word on `o_PE` in t+1. The earliest consumption is at the t+1 edge.
- Eject latency: `capture` at edge t gives `rx_valid = 1` with the packet at the head in t+1.
- `o_PE`, `tx_ready` and `rx_valid` depend only on registered state. `consumed` and `capture` are combinational from `i_PE`/`i_align`.
- Reset mid-operation discards the FIFO and link contents. No partial word appears on `o_PE`.

## Configuration
- `EDGE_PORT_STATS_EN` defined:
  - `inj_count` increments on every accepted load.
  - `ej_count` increments on every `capture`.
  - Both are 16-bit, saturating at 0xFFFF, and cleared by reset.
- Not defined: both ports are driven constant 0 and no counter logic is built.

## Test plan
Defaults throughout; `EDGE_I = 31`, `N = 1024`.
- Reset: hold `rst_n = 0` mid-cycle → `o_PE` key = 1024, `rx_valid = 0`, `rx_count = 0`; after release `tx_ready = 1`.
- Inject: tx `{5, 0x2A}` → `o_PE = {5, 0x2A}` next cycle. Then `i_align = 1` with `i_PE` key 1024 → `o_PE` key = 1024 the cycle after; `inj_count = 1` when `EDGE_PORT_STATS_EN` is defined.
- Eject: empty link, `i_align = 1`, `i_PE = {40, 0x11}` → next cycle `rx_valid = 1`, `rx_data = {40, 0x11}`, `rx_count = 1`.
- Exchange: `link_reg = {3, 7}`, `i_PE = {50, 9}`, `i_align = 1` → FIFO receives `{50, 9}`, link empty; `i_PE` key 31 instead → no exchange.
- Backpressure: `rx_ready = 0`, eight captures → `rx_count = 8`, `o_PE` key = 2047, a ninth `i_PE = {60, 1}` is not captured. `tx_ready` is 0 from `rx_count = 7` on. One pop → capture resumes.
- Illegal tx: tx `{40, 0}` → handshake completes, `o_PE` stays `{1024, 0}`, `err_key = 1` until reset.
